// File: rtl/midi_msg_parser_pkg.sv
// rtl/midi_msg_parser_pkg.sv - status nibbles, byte-class bounds and FSM states for midi_msg_parser
package midi_msg_parser_pkg;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] POLY_AT  = 4'hA;
  localparam logic [3:0] CC       = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CH_AT    = 4'hD;
  localparam logic [3:0] PITCH    = 4'hE;

  localparam logic [7:0] SYS_BASE = 8'hF0;
  localparam logic [7:0] RT_BASE  = 8'hF8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_D1 = 2'd1,
    ST_WAIT_D2 = 2'd2
  } state_t;

  function automatic logic is_one_data(input logic [3:0] t);
    case (t)
      PROG, CH_AT:                           return 1'b1;
      NOTE_OFF, NOTE_ON, POLY_AT, CC, PITCH: return 1'b0;
      default:                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/midi_msg_parser.sv
// rtl/midi_msg_parser.sv - MIDI byte stream to Note On/Off events with running status
// Optional MIDI_PARSER_CC_EN: Control Change messages also become events, flagged on ev_is_cc.
module midi_msg_parser
  import midi_msg_parser_pkg::*;
#(
  parameter bit         OMNI    = 1'b1,
  parameter logic [3:0] CHANNEL = 4'd1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  input  logic       rx_error,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic       ev_note_on,
  output logic [3:0] ev_channel,
  output logic [6:0] ev_note,
  output logic [6:0] ev_velocity,
  output logic       overflow
`ifdef MIDI_PARSER_CC_EN
  ,
  output logic       ev_is_cc
`endif
);

  state_t     r_state;
  logic [3:0] r_type;
  logic [3:0] r_chan;
  logic [6:0] r_d1;

  logic       r_ev_valid;
  logic       r_ev_on;
  logic [3:0] r_ev_chan;
  logic [6:0] r_ev_note;
  logic [6:0] r_ev_vel;
  logic       r_overflow;

  logic       w_is_rt;
  logic       w_is_sys;
  logic       w_msg_done;
  logic       w_type_note;
  logic       w_type_cc;
  logic       w_chan_ok;
  logic       w_new_ev;
  logic       w_new_on;
  logic [6:0] w_new_vel;

  assign w_is_rt     = rx_byte >= RT_BASE;
  assign w_is_sys    = (rx_byte >= SYS_BASE) && !w_is_rt;
  // The second data byte goes straight into the event register, so no d2 storage is needed.
  assign w_msg_done  = rx_valid && !rx_error && !rx_byte[7] && (r_state == ST_WAIT_D2);
  assign w_type_note = (r_type == NOTE_OFF) || (r_type == NOTE_ON);
`ifdef MIDI_PARSER_CC_EN
  assign w_type_cc   = (r_type == CC);
`else
  assign w_type_cc   = 1'b0;
`endif
  assign w_chan_ok   = OMNI || (r_chan == CHANNEL);
  assign w_new_ev    = w_msg_done && w_chan_ok && (w_type_note || w_type_cc);
  assign w_new_on    = (r_type == NOTE_ON) && (rx_byte[6:0] != 7'd0);
  assign w_new_vel   = (w_type_cc || w_new_on) ? rx_byte[6:0] : 7'd0;

`ifdef MIDI_PARSER_CC_EN
  logic r_ev_cc;
  assign ev_is_cc = r_ev_cc;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_type     <= 4'd0;
      r_chan     <= 4'd0;
      r_d1       <= 7'd0;
      r_ev_valid <= 1'b0;
      r_ev_on    <= 1'b0;
      r_ev_chan  <= 4'd0;
      r_ev_note  <= 7'd0;
      r_ev_vel   <= 7'd0;
      r_overflow <= 1'b0;
`ifdef MIDI_PARSER_CC_EN
      r_ev_cc    <= 1'b0;
`endif
    end else begin
      if (rx_error) begin
        if (r_state != ST_IDLE) r_state <= ST_WAIT_D1;
      end else if (rx_valid && !w_is_rt) begin
        if (w_is_sys) begin
          r_state <= ST_IDLE;
          r_type  <= 4'd0;
          r_chan  <= 4'd0;
        end else if (rx_byte[7]) begin
          r_type  <= rx_byte[7:4];
          r_chan  <= rx_byte[3:0];
          r_state <= ST_WAIT_D1;
        end else begin
          case (r_state)
            ST_WAIT_D1: begin
              r_d1    <= rx_byte[6:0];
              r_state <= is_one_data(r_type) ? ST_WAIT_D1 : ST_WAIT_D2;
            end
            ST_WAIT_D2: r_state <= ST_WAIT_D1;
            default:    r_state <= ST_IDLE;
          endcase
        end
      end

      // A held event that is not being accepted wins; the newcomer is dropped.
      if (w_new_ev) begin
        if (!r_ev_valid || ev_ready) begin
          r_ev_valid <= 1'b1;
          r_ev_on    <= w_new_on;
          r_ev_chan  <= r_chan;
          r_ev_note  <= r_d1;
          r_ev_vel   <= w_new_vel;
`ifdef MIDI_PARSER_CC_EN
          r_ev_cc    <= w_type_cc;
`endif
        end else begin
          r_overflow <= 1'b1;
        end
      end else if (r_ev_valid && ev_ready) begin
        r_ev_valid <= 1'b0;
      end
    end
  end

  assign ev_valid    = r_ev_valid;
  assign ev_note_on  = r_ev_on;
  assign ev_channel  = r_ev_chan;
  assign ev_note     = r_ev_note;
  assign ev_velocity = r_ev_vel;
  assign overflow    = r_overflow;

endmodule
